// File: rtl/grf_pkg.sv
// Shared defaults and helpers for the pipelined general register file.
package grf_pkg;
  localparam int GRF_DW   = 32;
  localparam int GRF_NREG = 32;
  localparam int GRF_AW   = 5;
  localparam int GRF_PMAX = 3;

  // Bits needed to hold values 0..pmax
  function automatic int cnt_width(input int pmax);
    int w;
    w = 1;
    while ((1 << w) < (pmax + 1)) w++;
    return w;
  endfunction
endpackage

// File: rtl/pipe_grf_if.sv
// Read/write/issue bus of the register file; master drives, slave is the file.
interface pipe_grf_if
  import grf_pkg::*;
#(
  parameter int DW = GRF_DW,
  parameter int AW = GRF_AW
);
  logic [AW-1:0] A1, A2, A3, iss_addr;
  logic [DW-1:0] RD1, RD2, WD;
  logic [31:0]   PC;
  logic          WE, iss_en, flush;
  logic          busy1, busy2, err;

  modport master (output A1, A2, WE, A3, WD, PC, iss_en, iss_addr, flush,
                  input  RD1, RD2, busy1, busy2, err);
  modport slave  (input  A1, A2, WE, A3, WD, PC, iss_en, iss_addr, flush,
                  output RD1, RD2, busy1, busy2, err);
endinterface

// File: rtl/pipe_grf_pend_ctr.sv
// Saturating pending-write counter for one register.
module pend_ctr #(
  parameter int PMAX = 3,
  parameter int CW   = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_inc,
  input  logic          i_dec,
  input  logic          i_clr,
  output logic [CW-1:0] o_cnt,
  output logic          o_ovf
);
  localparam logic [CW-1:0] MAX_C = CW'(PMAX);

  logic [CW-1:0] r_cnt;

  assign o_cnt = r_cnt;
  // Simultaneous inc and dec cancel, so only a lone inc at max overflows
  assign o_ovf = !i_clr && i_inc && !i_dec && (r_cnt == MAX_C);

  always_ff @(posedge clk) begin
    if (reset || i_clr)
      r_cnt <= '0;
    else if (i_inc && !i_dec && r_cnt != MAX_C)
      r_cnt <= r_cnt + CW'(1);
    else if (i_dec && !i_inc && r_cnt != '0)
      r_cnt <= r_cnt - CW'(1);
  end
endmodule

// File: rtl/pipe_grf.sv
// Two-read/one-write register file with per-register pending-write scoreboard.
module pipe_grf
  import grf_pkg::*;
#(
  parameter int DW     = GRF_DW,
  parameter int NREG   = GRF_NREG,
  parameter int AW     = GRF_AW,
  parameter int PMAX   = GRF_PMAX,
  parameter bit BYPASS = 1'b1,
  parameter bit TRACE  = 1'b1
) (
  input logic       clk,
  input logic       reset,
  pipe_grf_if.slave bus
);
  localparam int          CW     = cnt_width(PMAX);
  localparam logic [AW:0] NREG_A = (AW+1)'(NREG);

  logic [DW-1:0] r_regs [NREG];
  logic [CW-1:0] w_cnt  [NREG];
  logic [NREG-1:0] w_ovf;
  logic          r_err;
  logic          w_a3_ok, w_acc;
  logic [AW-1:0] w_a    [2];
  logic [DW-1:0] w_rd   [2];
  logic          w_busy [2];

  assign w_a3_ok = (bus.A3 != '0) && ({1'b0, bus.A3} < NREG_A);
  assign w_acc   = bus.WE && w_a3_ok && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
    end else if (w_acc) begin
      r_regs[bus.A3] <= bus.WD;
    end
  end

  assign w_cnt[0] = '0;
  assign w_ovf[0] = 1'b0;

  for (genvar i = 1; i < NREG; i++) begin : g_ctr
    pend_ctr #(.PMAX(PMAX), .CW(CW)) u_ctr (
      .clk   (clk),
      .reset (reset),
      .i_inc (bus.iss_en && bus.iss_addr == AW'(i)),
      .i_dec (w_acc && bus.A3 == AW'(i)),
      .i_clr (bus.flush),
      .o_cnt (w_cnt[i]),
      .o_ovf (w_ovf[i])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) r_err <= 1'b0;
    else       r_err <= r_err | (|w_ovf);
  end

  assign w_a[0] = bus.A1;
  assign w_a[1] = bus.A2;

  for (genvar p = 0; p < 2; p++) begin : g_rd
    logic w_ok, w_hit;
    assign w_ok  = (w_a[p] != '0) && ({1'b0, w_a[p]} < NREG_A);
    assign w_hit = BYPASS && bus.WE && (bus.A3 == w_a[p]);
    assign w_rd[p] = !w_ok ? '0 : (w_hit ? bus.WD : r_regs[w_a[p]]);
    // The last outstanding write landing this cycle is already forwardable
    assign w_busy[p] = w_ok && (w_cnt[w_a[p]] != '0) &&
                       !(w_hit && !reset && w_cnt[w_a[p]] == CW'(1));
  end

  assign bus.RD1   = w_rd[0];
  assign bus.RD2   = w_rd[1];
  assign bus.busy1 = w_busy[0];
  assign bus.busy2 = w_busy[1];
  assign bus.err   = r_err;

`ifndef SYNTHESIS
  if (TRACE) begin : g_trace
    always @(posedge clk) begin
      if (w_acc) $display("@%08h: $%2d <= %h", bus.PC, bus.A3, bus.WD);
    end
  end
`endif
endmodule

// File: doc/pipe_grf.md
PIPE_GRF -- requirements
Module: pipe_grf

Interface
REQ-001 Parameter DW, 32, data width of every register in bits.
REQ-002 Parameter NREG, 32, number of architectural registers (2..32); register 0 is hardwired zero.
REQ-003 Parameter AW, 5, address width; SHALL satisfy 2^AW >= NREG.
REQ-004 Parameter PMAX, 3, maximum in-flight pending writes tracked per register (1..7).
REQ-005 Parameter BYPASS, 1, 1 = same-cycle write-to-read forwarding enabled, 0 = disabled.
REQ-006 Parameter TRACE, 1, 1 = emit a simulation write trace line, 0 = silent.
REQ-007 clk  in  1  single clock; all state updates on rising edge.
REQ-008 reset  in  1  synchronous, active-high reset.
REQ-009 A1, A2  in  AW  read addresses, ports 1 and 2.
REQ-010 RD1, RD2  out  DW  read data, ports 1 and 2.
REQ-011 WE  in  1  writeback enable.
REQ-012 A3  in  AW  writeback address.
REQ-013 WD  in  DW  writeback data.
REQ-014 PC  in  32  PC of the writing instruction, trace only.
REQ-015 iss_en  in  1  issue: an instruction targeting iss_addr entered the pipeline.
REQ-016 iss_addr  in  AW  destination register of the issuing instruction.
REQ-017 flush  in  1  discard all pending-write tracking.
REQ-018 busy1, busy2  out  1  register at A1/A2 has an outstanding write not yet forwardable.
REQ-019 err  out  1  sticky pending-counter overflow flag.

Function
REQ-020 RDn SHALL be combinational: 0 if An==0 or An>=NREG, else stored value.
REQ-021 With BYPASS=1, WE=1, A3==An, A3!=0 and A3<NREG, RDn SHALL equal WD in the same cycle.
REQ-022 On a rising edge with WE=1, A3!=0, A3<NREG and reset=0, register A3 SHALL take WD; otherwise the write is dropped.
REQ-023 With TRACE=1, each accepted write SHALL print "@<PC hex 8>: $<A3 dec 2> <= <WD hex>" once, at the edge it commits.
REQ-024 Each register 1..NREG-1 SHALL hold a pending counter 0..PMAX; register 0 never counts.
REQ-025 Counter update per edge: iss_en only -> +1; accepted WE only -> -1; both to the same register -> unchanged.
REQ-026 Decrement at 0 SHALL be ignored (untracked write is legal); the data write still commits.
REQ-027 Increment at PMAX SHALL be ignored and SHALL set err at that edge.
REQ-028 flush=1 SHALL clear all counters at the edge, overriding same-cycle iss_en and WE decrements; the data write still commits.
REQ-029 busyn SHALL be 1 iff counter[An]!=0, except 0 when BYPASS=1, an accepted WE targets An this cycle and counter[An]==1.
REQ-030 busyn SHALL be 0 for An==0 or An>=NREG.
REQ-031 Read ports SHALL be independent; A1==A2 yields identical RD and busy outputs.

Reset
REQ-032 While reset=1 at an edge: all registers 0, all counters 0, err 0; WE, iss_en, flush ignored; no trace output.
REQ-033 During reset cycle outputs SHALL reflect pre-edge state; after the edge RDn=0, busyn=0, err=0.
REQ-034 Reset asserted mid-operation SHALL discard all in-flight pending state with no residual busy.

Structure
REQ-035 Package grf_pkg SHALL hold default DW/NREG/AW/PMAX and the counter-width function ceil(log2(PMAX+1)).
REQ-036 Sub-module pend_ctr (one counter with inc/dec/clr/sat/overflow) SHALL be instantiated per register 1..NREG-1.

Verification
REQ-037 Reset, write $5=0x1234 with PC=0x3000 -> next cycle RD1(A1=5)=0x1234; trace "@00003000: $ 5 <= 00001234".
REQ-038 WE=1, A3=0, WD=0xFFFFFFFF -> RD1(A1=0)=0, no trace.
REQ-039 BYPASS=1, A1=A3=7, WE=1, WD=0xAB -> RD1=0xAB same cycle; BYPASS=0 -> old value.
REQ-040 iss $9 twice -> busy1(A1=9)=1; one writeback -> busy1=1; second writeback cycle -> busy1=0 (bypass), afterwards 0.
REQ-041 PMAX=3: four issues to $4 -> counter 3, err=1 after fourth; flush -> busy=0, err stays 1 until reset.
REQ-042 iss_en and WE both to $6 in one cycle with counter 1 -> counter stays 1, busy remains 1.
